// File: rtl/qspi_pkg.sv
// Shared QSPI definitions for the flash responder and the player's flash reader.
// Contents: opcode constants, responder state enum, default dummy-cycle count.
// Optional feature macro: QSPI_RESP_STATUS_EN adds the STATUS state.
package qspi_pkg;

    localparam logic [7:0] OP_READ_QUAD   = 8'h6B;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;

    localparam int unsigned DEFAULT_DUMMY = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
`ifdef QSPI_RESP_STATUS_EN
        , StStatus
`endif
    } qspi_state_e;

endpackage

// File: rtl/qspi_in_sync.sv
// Input conditioning for the QSPI responder.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   async_in[3:0]   raw pins {hold_n, di, cs_n, sck}
//   sync_out[3:0]   2-flop synchronized copies, same bit order
//   sck_rise/fall   one-cycle pulses on synchronized SCK edges
//   cs_rise/fall    one-cycle pulses on synchronized CS# edges
module qspi_in_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] async_in,
    output logic [3:0] sync_out,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_rise,
    output logic       cs_fall
);

    // Reset to an idle bus (SCK low, CS# high, HOLD# high) so no edge fires after reset.
    localparam logic [3:0] IdleBus = 4'b1010;

    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= IdleBus;
            sync_q <= IdleBus;
            prev_q <= IdleBus[1:0];
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q[1:0];
        end
    end

    assign sync_out = sync_q;
    assign sck_rise = sync_q[0] & ~prev_q[0];
    assign sck_fall = ~sync_q[0] & prev_q[0];
    assign cs_rise  = sync_q[1] & ~prev_q[1];
    assign cs_fall  = ~sync_q[1] & prev_q[1];

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: target side of Fast Read Quad Output (6Bh).
// Oversamples SCK/CS#/IO0/HOLD# on clk, decodes command/address/dummy, then
// streams bytes from a memory port as nibbles (high first) on IO[3:0].
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   spi_clk, cs_n, spi_di,    host pins (asynchronous to clk)
//   spi_hold_n
//   io_out, io_oe             IO[3:0] drive values and per-line enables
//   mem_rd_en, mem_addr       one-cycle read strobe and byte address
//   mem_rdata, mem_rvalid     read return
//   underrun                  sticky: a nibble was due with no byte buffered
// Optional feature macro: QSPI_RESP_STATUS_EN (opcode 05h returns status 0x00 on IO1).
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DUMMY_CYCLES = DEFAULT_DUMMY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              cs_n,
    input  logic              spi_di,
    input  logic              spi_hold_n,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              underrun
);

    localparam logic [7:0]        AddrLast  = 8'(ADDR_W - 1);
    localparam logic [7:0]        DummyLast = 8'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
`ifdef QSPI_RESP_STATUS_EN
    localparam logic [7:0]        StatusByte = 8'h00;  // WIP=0, nothing else reported
`endif

    logic [3:0] pins_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       sck_s, di_s, hold_n_s;

    qspi_in_sync u_in_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in ({spi_hold_n, spi_di, cs_n, spi_clk}),
        .sync_out (pins_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    assign sck_s    = pins_s[0];
    assign di_s     = pins_s[2];
    assign hold_n_s = pins_s[3];

    qspi_state_e       state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] sh_q;
    logic [7:0]        buf_q, cur_q;
    logic              buf_vld_q, cur_vld_q, rd_pend_q, nib_hi_q, hold_q;
    logic [3:0]        oe_q;

    // HOLD# only takes effect once SCK is low; once active it persists until release.
    logic held, rise_ok, fall_ok, rvalid_ok, byte_avail;
    logic [7:0] byte_in;

    assign held       = ~hold_n_s & (hold_q | ~sck_s);
    assign rise_ok    = sck_rise & ~held;
    assign fall_ok    = sck_fall & ~held;
    assign rvalid_ok  = mem_rvalid & rd_pend_q;
    assign byte_avail = buf_vld_q | rvalid_ok;
    assign byte_in    = buf_vld_q ? buf_q : mem_rdata;

    // Enables are masked while held; io_out keeps its value so release restores it.
    assign io_oe = hold_q ? 4'h0 : oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_q      <= '0;
            buf_q     <= '0;
            cur_q     <= '0;
            buf_vld_q <= 1'b0;
            cur_vld_q <= 1'b0;
            rd_pend_q <= 1'b0;
            nib_hi_q  <= 1'b1;
            hold_q    <= 1'b0;
            oe_q      <= 4'h0;
            io_out    <= 4'h0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            underrun  <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            hold_q    <= held;

            if (rvalid_ok) begin
                buf_q     <= mem_rdata;
                buf_vld_q <= 1'b1;
                rd_pend_q <= 1'b0;
            end

            if (cs_rise) begin
                // Dropping rd_pend_q makes any late mem_rvalid get ignored.
                state_q   <= StIdle;
                oe_q      <= 4'h0;
                buf_vld_q <= 1'b0;
                cur_vld_q <= 1'b0;
                rd_pend_q <= 1'b0;
                hold_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q  <= StCmd;
                            cnt_q    <= '0;
                            underrun <= 1'b0;
                            io_out   <= 4'h0;
                        end
                    end
                    StCmd: begin
                        if (rise_ok) begin
                            sh_q  <= {sh_q[ADDR_W-2:0], di_s};
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd7) begin
                                cnt_q <= '0;
                                case ({sh_q[6:0], di_s})
                                    OP_READ_QUAD:   state_q <= StAddr;
`ifdef QSPI_RESP_STATUS_EN
                                    OP_READ_STATUS: state_q <= StStatus;
`endif
                                    default:        state_q <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StAddr: begin
                        if (rise_ok) begin
                            sh_q  <= {sh_q[ADDR_W-2:0], di_s};
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == AddrLast) begin
                                cnt_q     <= '0;
                                mem_addr  <= {sh_q[ADDR_W-2:0], di_s};
                                mem_rd_en <= 1'b1;
                                rd_pend_q <= 1'b1;
                                nib_hi_q  <= 1'b1;
                                state_q   <= StDummy;
                            end
                        end
                    end
                    StDummy: begin
                        if (rise_ok) begin
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == DummyLast) begin
                                cnt_q   <= '0;
                                state_q <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (fall_ok) begin
                            oe_q     <= 4'hF;
                            nib_hi_q <= ~nib_hi_q;
                            if (nib_hi_q) begin
                                if (byte_avail) begin
                                    // Move the prefetched byte out and fetch the next one.
                                    io_out    <= byte_in[7:4];
                                    cur_q     <= byte_in;
                                    cur_vld_q <= 1'b1;
                                    buf_vld_q <= 1'b0;
                                    mem_addr  <= mem_addr + AddrOne;
                                    mem_rd_en <= 1'b1;
                                    rd_pend_q <= 1'b1;
                                end else begin
                                    io_out    <= 4'hF;
                                    cur_vld_q <= 1'b0;
                                    underrun  <= 1'b1;
                                end
                            end else if (cur_vld_q) begin
                                io_out <= cur_q[3:0];
                            end else begin
                                io_out   <= 4'hF;
                                underrun <= 1'b1;
                            end
                        end
                    end
`ifdef QSPI_RESP_STATUS_EN
                    StStatus: begin
                        if (fall_ok) begin
                            oe_q   <= 4'b0010;
                            io_out <= {2'b00, StatusByte[3'd7 - cnt_q[2:0]], 1'b0};
                            cnt_q  <= cnt_q + 8'd1;
                        end
                    end
`endif
                    StIgnore: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;

    localparam int Half = 6;  // SCK half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        cs_n = 1'b1;
    logic        spi_di = 1'b0;
    logic        spi_hold_n = 1'b1;
    logic [3:0]  io_out, io_oe;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_rvalid = 1'b0;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    // Memory model: fixed latency in clk cycles, logs every read address.
    int          lat_clk = 4;
    logic [23:0] rd_log [16];
    int          rd_count = 0;
    logic        busy = 1'b0;
    int          wait_cnt = 0;
    logic [23:0] pend_addr = '0;

    always #5 clk = ~clk;

    qspi_flash_responder #(
        .ADDR_W       (24),
        .DUMMY_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .cs_n       (cs_n),
        .spi_di     (spi_di),
        .spi_hold_n (spi_hold_n),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .underrun   (underrun)
    );

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h000010) return 8'hA5;
        if (a == 24'h000011) return 8'h3C;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_rd_en) begin
            rd_log[rd_count % 16] <= mem_addr;
            rd_count  <= rd_count + 1;
            busy      <= 1'b1;
            pend_addr <= mem_addr;
            wait_cnt  <= lat_clk;
        end else if (busy) begin
            if (wait_cnt <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_byte(pend_addr);
                busy       <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_pulse();
        wait_clk(Half);
        spi_clk = 1'b1;
        wait_clk(Half);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            spi_di = v[i];
            sck_pulse();
        end
    endtask

    task automatic start_cmd(input logic [7:0] op);
        cs_n = 1'b0;
        wait_clk(Half);
        send_bits({24'h0, op}, 8);
    endtask

    task automatic start_read(input logic [23:0] addr);
        start_cmd(8'h6B);
        send_bits({8'h0, addr}, 24);
    endtask

    task automatic dummy();
        repeat (8) sck_pulse();
    endtask

    // Sample what was presented on the previous fall, then clock one SCK period.
    task automatic read_nib(output logic [3:0] n, output logic [3:0] oe);
        wait_clk(Half);
        n  = io_out;
        oe = io_oe;
        spi_clk = 1'b1;
        wait_clk(Half);
        spi_clk = 1'b0;
    endtask

    task automatic end_txn();
        wait_clk(Half);
        cs_n = 1'b1;
        wait_clk(2 * Half);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        checks++; if (io_out !== 4'h0) begin errors++; $display("FAIL reset_io_out got %h want 0", io_out); end
        checks++; if (io_oe !== 4'h0) begin errors++; $display("FAIL reset_io_oe got %h want 0", io_oe); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
        checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_basic_read();
        logic [15:0] exp;
        logic [3:0]  n, oe;
        int          base;
        exp  = 16'hA53C;
        base = rd_count;
        start_read(24'h000010);
        checks++; if (io_oe !== 4'h0) begin errors++; $display("FAIL basic_oe_pre got %h want 0", io_oe); end
        dummy();
        for (int i = 0; i < 4; i++) begin
            read_nib(n, oe);
            checks++; if (n !== exp[15 - 4*i -: 4]) begin errors++; $display("FAIL basic_nib%0d got %h want %h", i, n, exp[15 - 4*i -: 4]); end
            checks++; if (oe !== 4'hF) begin errors++; $display("FAIL basic_oe%0d got %h want f", i, oe); end
        end
        checks++; if (rd_log[base % 16] !== 24'h000010) begin errors++; $display("FAIL basic_rd_addr got %h want 000010", rd_log[base % 16]); end
        end_txn();
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        logic [23:0] ea [4];
        logic [3:0]  n, oe;
        int          base;
        exp = 32'hA55A5B58;
        ea  = '{24'hFFFFFF, 24'h000000, 24'h000001, 24'h000002};
        base = rd_count;
        start_read(24'hFFFFFF);
        dummy();
        for (int i = 0; i < 8; i++) begin
            read_nib(n, oe);
            checks++; if (n !== exp[31 - 4*i -: 4]) begin errors++; $display("FAIL wrap_nib%0d got %h want %h", i, n, exp[31 - 4*i -: 4]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_log[(base + i) % 16] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, rd_log[(base + i) % 16], ea[i]); end
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL wrap_underrun got %b want 0", underrun); end
        end_txn();
    endtask

    task automatic test_ignore();
        logic [3:0] n, oe;
        start_cmd(8'h9F);
        for (int i = 0; i < 32; i++) begin
            read_nib(n, oe);
            checks++; if (oe !== 4'h0) begin errors++; $display("FAIL ignore_oe%0d got %h want 0", i, oe); end
        end
        end_txn();
        start_read(24'h000010);
        dummy();
        read_nib(n, oe);
        checks++; if (n !== 4'hA) begin errors++; $display("FAIL ignore_next_nib0 got %h want a", n); end
        read_nib(n, oe);
        checks++; if (n !== 4'h5) begin errors++; $display("FAIL ignore_next_nib1 got %h want 5", n); end
        end_txn();
    endtask

    task automatic test_hold();
        logic [3:0] n, oe;
        start_read(24'h000010);
        dummy();
        read_nib(n, oe);
        read_nib(n, oe);
        wait_clk(Half);
        checks++; if (io_out !== 4'h3) begin errors++; $display("FAIL hold_nib2 got %h want 3", io_out); end
        spi_clk = 1'b1;
        wait_clk(Half - 2);
        spi_hold_n = 1'b0;  // asserted while SCK high: effective at the coming SCK low
        wait_clk(2);
        spi_clk = 1'b0;
        wait_clk(Half);
        checks++; if (io_oe !== 4'h0) begin errors++; $display("FAIL hold_oe got %h want 0", io_oe); end
        repeat (3) sck_pulse();
        wait_clk(Half);
        checks++; if (io_oe !== 4'h0) begin errors++; $display("FAIL hold_oe_late got %h want 0", io_oe); end
        spi_hold_n = 1'b1;
        wait_clk(Half);
        checks++; if (io_oe !== 4'hF) begin errors++; $display("FAIL hold_release_oe got %h want f", io_oe); end
        checks++; if (io_out !== 4'h3) begin errors++; $display("FAIL hold_release_out got %h want 3", io_out); end
        sck_pulse();
        read_nib(n, oe);
        checks++; if (n !== 4'hC) begin errors++; $display("FAIL hold_nib3 got %h want c", n); end
        end_txn();
    endtask

    task automatic test_underrun();
        logic [15:0] exp;
        logic [3:0]  n, oe;
        exp = 16'hA5FF;
        lat_clk = 3 * 2 * Half;
        start_read(24'h000010);
        dummy();
        for (int i = 0; i < 4; i++) begin
            read_nib(n, oe);
            checks++; if (n !== exp[15 - 4*i -: 4]) begin errors++; $display("FAIL underrun_nib%0d got %h want %h", i, n, exp[15 - 4*i -: 4]); end
        end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b want 1", underrun); end
        end_txn();
        lat_clk = 4;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", underrun); end
        cs_n = 1'b0;
        wait_clk(Half);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", underrun); end
        cs_n = 1'b1;
        wait_clk(2 * Half);
    endtask

    task automatic test_restart();
        logic [15:0] exp;
        logic [3:0]  n, oe;
        int          base;
        exp = 16'h7A7B;
        start_cmd(8'h6B);
        send_bits(32'h00000ABC, 12);
        cs_n = 1'b1;
        wait_clk(2 * Half);
        base = rd_count;
        start_read(24'h000020);
        dummy();
        for (int i = 0; i < 4; i++) begin
            read_nib(n, oe);
            checks++; if (n !== exp[15 - 4*i -: 4]) begin errors++; $display("FAIL restart_nib%0d got %h want %h", i, n, exp[15 - 4*i -: 4]); end
        end
        checks++; if (rd_log[base % 16] !== 24'h000020) begin errors++; $display("FAIL restart_addr got %h want 000020", rd_log[base % 16]); end
        end_txn();
    endtask

`ifdef QSPI_RESP_STATUS_EN
    task automatic test_status();
        logic [3:0] n, oe;
        start_cmd(8'h05);
        for (int i = 0; i < 8; i++) begin
            read_nib(n, oe);
            checks++; if (oe !== 4'b0010) begin errors++; $display("FAIL status_oe%0d got %h want 2", i, oe); end
            checks++; if (n[1] !== 1'b0) begin errors++; $display("FAIL status_bit%0d got %b want 0", i, n[1]); end
        end
        end_txn();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_wrap();
        test_ignore();
        test_hold();
        test_underrun();
        test_restart();
`ifdef QSPI_RESP_STATUS_EN
        test_status();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI flash responder that emulates the target side of the Fast Read Quad Output (6Bh) transaction our video player issues. It oversamples the host's SCK/CS#/IO0/HOLD# on the system clock, decodes command, address and dummy phases, then streams bytes from a backing memory port as nibbles on IO[3:0]. It is used for FPGA bring-up and for closed-loop simulation against the player's flash reader.

## Interface
- `ADDR_W`, 24: address bits captured; byte address wraps at 2^ADDR_W.
- `DUMMY_CYCLES`, 8: SCK cycles between the last address bit and the first data nibble.
- `clk` in 1: system clock; at least 8× SCK frequency.
- `rst` in 1: reset, synchronous, active-high.
- `spi_clk` in 1: host SCK, asynchronous to `clk`.
- `cs_n` in 1: host chip select, active low.
- `spi_di` in 1: host IO0 (command/address input).
- `spi_hold_n` in 1: host HOLD#, active low.
- `io_out` out 4: IO[3:0] drive values.
- `io_oe` out 4: per-line output enable (1 = responder drives).
- `mem_rd_en` out 1: one-cycle read strobe.
- `mem_addr` out ADDR_W: byte address for the read.
- `mem_rdata` in 8: read data.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `underrun` out 1: sticky, set when a nibble was due with no byte buffered; cleared by reset or CS# falling.

## Operation
- Input path: 2-flop synchronizers on `spi_clk`, `cs_n`, `spi_di`, `spi_hold_n`; rise/fall detect on the synchronized SCK.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE, plus STATUS when the macro is compiled in.
- IDLE → CMD on synchronized CS# falling. Clears the bit counter and `underrun`.
- CMD: shift 8 bits of IO0 MSB-first on SCK rise.
  - 0x6B → ADDR.
  - 0x05 → STATUS (macro only).
  - Any other opcode → IGNORE.
- ADDR: shift ADDR_W bits MSB-first on SCK rise. On the last bit, issue `mem_rd_en` with the captured address, then → DUMMY.
- DUMMY: count DUMMY_CYCLES SCK rises, then → DATA.
- DATA:
  - Drive `io_oe`=4'hF on the first SCK fall after entering DATA.
  - Each SCK fall presents the next nibble, high nibble first.
  - On presenting a high nibble, post-increment the address and issue the next `mem_rd_en` (one-byte prefetch).
  - If no byte is buffered when a nibble is due: drive 4'hF and set `underrun`.
- IGNORE: outputs off until CS# rises.
- CS# rise (synchronized), in any state: → IDLE within the same cycle, `io_oe`=0. A `mem_rvalid` arriving afterwards is discarded.
- HOLD#:
  - Synchronized HOLD# low while synchronized SCK is low freezes all counters and the state.
  - `io_oe`=0 while held; SCK edges are ignored.
  - On release, the previous `io_oe` and `io_out` are restored and the transaction continues.
  - HOLD# low while SCK is high takes effect at the next SCK low.
- Reset values: state IDLE, `io_out`=0, `io_oe`=0, `mem_rd_en`=0, `mem_addr`=0, `underrun`=0, buffer empty.

## Timing
- Input to decision latency: 3 `clk` (2 sync + edge detect).
- Output nibble is valid no later than 4 `clk` after the SCK fall at the pin, so an SCK half-period of at least 4 `clk` guarantees setup for the host's rising-edge sample.
- Memory latency: `mem_rvalid` must return within 2 SCK periods of `mem_rd_en`; otherwise `underrun` is the specified result. Only one read is ever outstanding.
- Address wraps from 2^ADDR_W−1 to 0 with no gap in the nibble stream.
- Simultaneous CS# rise and `mem_rvalid`: CS# wins and the buffer is cleared.

## Configuration
- `QSPI_RESP_STATUS_EN` defined:
  - Opcode 0x05 enters STATUS.
  - STATUS drives IO1 only (`io_oe`=4'b0010) with 0x00 (WIP=0), MSB-first, one bit per SCK fall, repeating until CS# rises.
- Undefined: 0x05 goes to IGNORE and no STATUS logic is built.

## Structure
- Shared package `qspi_pkg`:
  - Opcode constants `OP_READ_QUAD`=8'h6B and `OP_READ_STATUS`=8'h05.
  - The state enum.
  - The default dummy count.
  - Both this block and the player's flash reader import it.
- One sub-module, `qspi_in_sync`: the 4-bit 2-flop synchronizer plus the SCK rise/fall detector.

## Test plan
- Opcode 6Bh, address 0x000010, 8 dummy, memory holds 0xA5,0x3C at 0x10/0x11 → nibbles A,5,3,C on IO; `io_oe`=F from the first data fall.
- Address 0xFFFFFF, 4 bytes read → `mem_addr` sequence FFFFFF, 000000, 000001, 000002; no stall.
- Opcode 0x9F → `io_oe` stays 0 for the whole transaction; next 6Bh transaction reads correctly.
- HOLD# low for 3 SCK periods after the 3rd nibble → `io_oe`=0, no SCK edges counted; after release the 4th nibble equals the expected value.
- Memory latency of 3 SCK periods → `underrun`=1 and IO=F; a CS# toggle clears `underrun`.
- CS# raised mid-address, then a new 6Bh to 0x000020 → clean restart, data from 0x20. With `QSPI_RESP_STATUS_EN`, 05h → IO1 reads 0x00 with `io_oe`=4'b0010.
